hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard unit: forwarding selects, load-use stall and branch flush.
// Shadows the E/M/W destination/source fields so all decisions are made locally.
module hazard_unit (
   input  logic       clk,
   input  logic       resetn,
   input  logic [4:0] rs1D,
   input  logic [4:0] rs2D,
   input  logic [4:0] rdD,
   input  logic       regwriteD,
   input  logic       loadD,
   input  logic       pcsrcE,
   input  logic       hold,
   output logic [1:0] forwardAE,
   output logic [1:0] forwardBE,
   output logic       stallF,
   output logic       stallD,
   output logic       flushD,
   output logic       flushE
);

   localparam int unsigned REG_W = 5;
   localparam int unsigned FWD_W = 2;

   localparam logic [FWD_W-1:0] FWD_RF  = FWD_W'(0);
   localparam logic [FWD_W-1:0] FWD_WB  = FWD_W'(1);
   localparam logic [FWD_W-1:0] FWD_MEM = FWD_W'(2);

   logic [REG_W-1:0] rs1E, rs2E, rdE, rdM, rdW;
   logic             regwriteE, loadE, regwriteM, regwriteW;

   logic [FWD_W-1:0] fwd_a, fwd_b;
   logic             lwstall;
   logic             flush_e_raw;

   // Hazard detection; x0 is excluded from every match
   always_comb begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;

      if (regwriteM && (rdM != '0) && (rdM == rs1E))
         fwd_a = FWD_MEM;
      else if (regwriteW && (rdW != '0) && (rdW == rs1E))
         fwd_a = FWD_WB;

      if (regwriteM && (rdM != '0) && (rdM == rs2E))
         fwd_b = FWD_MEM;
      else if (regwriteW && (rdW != '0) && (rdW == rs2E))
         fwd_b = FWD_WB;

      lwstall     = loadE && (rdE != '0) && ((rs1D == rdE) || (rs2D == rdE));
      flush_e_raw = (lwstall || pcsrcE) && !hold;
   end

   // Outputs forced low while reset is held
   always_comb begin
      forwardAE = FWD_RF;
      forwardBE = FWD_RF;
      stallF    = 1'b0;
      stallD    = 1'b0;
      flushD    = 1'b0;
      flushE    = 1'b0;
      if (resetn) begin
         forwardAE = fwd_a;
         forwardBE = fwd_b;
         stallF    = lwstall || hold;
         stallD    = lwstall || hold;
         flushD    = pcsrcE && !hold;
         flushE    = flush_e_raw;
      end
   end

   // Shadow pipeline: E takes D (or a bubble), M takes E, W takes M
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rs1E      <= '0;
         rs2E      <= '0;
         rdE       <= '0;
         regwriteE <= 1'b0;
         loadE     <= 1'b0;
         rdM       <= '0;
         regwriteM <= 1'b0;
         rdW       <= '0;
         regwriteW <= 1'b0;
      end else if (!hold) begin
         rdW       <= rdM;
         regwriteW <= regwriteM;
         rdM       <= rdE;
         regwriteM <= regwriteE;
         if (flush_e_raw) begin
            rs1E      <= '0;
            rs2E      <= '0;
            rdE       <= '0;
            regwriteE <= 1'b0;
            loadE     <= 1'b0;
         end else begin
            rs1E      <= rs1D;
            rs2E      <= rs2D;
            rdE       <= rdD;
            regwriteE <= regwriteD;
            loadE     <= loadD;
         end
      end
   end

endmodule
